// File: rtl/div_sequencer.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; result pulses on done XLEN+2 cycles after start
// (1 cycle for div-by-zero/overflow when FAST_SPEC=1). Holds the pipeline through stall; flush aborts.
module div_sequencer #(
   parameter int XLEN      = 32,
   parameter bit FAST_SPEC = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] Din1,
   input  logic [XLEN-1:0] Din2,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] Dout
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state, state_nx;
   logic            rem_sel, neg_q, neg_r;
   logic [XLEN-1:0] div_r, q_r, res_r;
   logic [XLEN:0]   rem_r;
   logic [CW-1:0]   cnt;

   logic            is_signed, a_neg, b_neg, div_zero, ovf, special, accept;
   logic [XLEN-1:0] a_abs, b_abs, spec_res, q_fix, r_fix;
   logic [XLEN+1:0] shifted, trial;

   assign is_signed = ~op[0];
   assign a_neg     = is_signed & Din1[XLEN-1];
   assign b_neg     = is_signed & Din2[XLEN-1];
   assign a_abs     = a_neg ? -Din1 : Din1;
   assign b_abs     = b_neg ? -Din2 : Din2;
   assign div_zero  = (Din2 == '0);
   assign ovf       = is_signed & (Din1 == MIN) & (Din2 == '1);
   assign special   = FAST_SPEC & (div_zero | ovf);
   assign spec_res  = div_zero ? (op[1] ? Din1 : '1) : (op[1] ? '0 : MIN);
   assign accept    = (state == IDLE) & start & ~flush;

   // Partial remainder stays below the divisor, so the top bit of trial is a clean borrow flag.
   assign shifted = {rem_r, q_r[XLEN-1]};
   assign trial   = shifted - {2'b00, div_r};
   assign q_fix   = neg_q ? -q_r : q_r;
   assign r_fix   = neg_r ? -rem_r[XLEN-1:0] : rem_r[XLEN-1:0];

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      done     = 1'b0;
      Dout     = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               stall    = 1'b1;
               state_nx = special ? DONE : CALC;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (cnt == LAST) state_nx = FIX;
         end
         FIX: begin
            stall    = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            Dout     = res_r;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         state_nx = IDLE;
         stall    = 1'b0;
         done     = 1'b0;
         Dout     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rem_sel <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div_r   <= '0;
         q_r     <= '0;
         rem_r   <= '0;
         res_r   <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rem_sel <= op[1];
                  // x/0 yields all ones regardless of the dividend's sign
                  neg_q   <= (a_neg ^ b_neg) & ~div_zero;
                  neg_r   <= a_neg;
                  div_r   <= b_abs;
                  q_r     <= a_abs;
                  rem_r   <= '0;
                  cnt     <= '0;
                  res_r   <= spec_res;
               end
            end
            CALC: begin
               q_r   <= {q_r[XLEN-2:0], ~trial[XLEN+1]};
               rem_r <= trial[XLEN+1] ? shifted[XLEN:0] : trial[XLEN:0];
               cnt   <= cnt + 1'b1;
            end
            FIX:     res_r <= rem_sel ? r_fix : q_fix;
            default: ;
         endcase
      end
   end

endmodule
